// File: rtl/if_queue.sv
// ---------------------------------------------------------------------------
// if_queue: instruction fetch queue sitting between the I-cache and decode.
// Circular FIFO of {pc, inst} entries with read/write pointers and an
// occupancy counter. Flush discards everything; empty queue presents NOP.
//
// Ports:
//   clk_i        - clock, all state updates on rising edge
//   rst_i        - synchronous active-high reset
//   flush_i      - redirect/flush, discards all queued instructions
//   enq_valid_i  - fetch presents an instruction
//   enq_pc_i     - PC of presented instruction
//   enq_inst_i   - instruction word from the I-cache
//   enq_ready_o  - queue can accept an instruction this cycle
//   deq_valid_o  - head instruction presented to decode
//   deq_pc_o     - PC of head entry (0 when empty)
//   deq_inst_o   - instruction of head entry (NOP_INST when empty)
//   deq_ready_i  - decode accepts the head entry
//   count_o      - number of occupied entries
// ---------------------------------------------------------------------------
module if_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   input  logic [31:0]                enq_pc_i,
   input  logic [31:0]                enq_inst_i,
   output logic                       enq_ready_o,
   output logic                       deq_valid_o,
   output logic [31:0]                deq_pc_o,
   output logic [31:0]                deq_inst_o,
   input  logic                       deq_ready_i,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // Elaboration-time guard on DEPTH.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("if_queue: DEPTH must be a power of two and at least 2");
   end

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic            enq_ready, deq_valid;
   logic            enq_fire,  deq_fire;
   entry_t          head;

   // Handshake qualification; ready looks only at the registered count so a
   // slot freed by a same-cycle dequeue is offered one cycle later.
   always_comb begin
      enq_ready = (count_q < CW'(DEPTH)) && !flush_i;
      deq_valid = (count_q != '0) && !flush_i;
      enq_fire  = enq_valid_i && enq_ready;
      deq_fire  = deq_valid && deq_ready_i;
   end

   // Next-state for pointers and occupancy; flush overrides both handshakes.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
         if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state; reset wins over flush and handshakes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array, intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (enq_fire && !rst_i) begin
         mem_q[wr_ptr_q] <= '{pc: enq_pc_i, inst: enq_inst_i};
      end
   end

   // Head presentation; empty queue shows pc 0 and NOP.
   always_comb begin
      head        = mem_q[rd_ptr_q];
      enq_ready_o = enq_ready;
      deq_valid_o = deq_valid;
      count_o     = count_q;
      if (count_q != '0) begin
         deq_pc_o   = head.pc;
         deq_inst_o = head.inst;
      end else begin
         deq_pc_o   = 32'h0;
         deq_inst_o = NOP_INST;
      end
   end

endmodule

// File: tb/tb_if_queue.sv
// ---------------------------------------------------------------------------
// tb_if_queue: self-checking bench for if_queue (DEPTH=4). Inputs change on
// the falling edge; outputs are compared #1 later against a queue-based
// reference model that is advanced at each rising edge.
// ---------------------------------------------------------------------------
module tb_if_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i, flush_i, enq_valid_i, deq_ready_i;
   logic [31:0] enq_pc_i, enq_inst_i;
   logic        enq_ready_o, deq_valid_o;
   logic [31:0] deq_pc_o, deq_inst_o;
   logic [2:0]  count_o;

   int errors = 0;
   int checks = 0;

   logic [63:0] mq[$];   // reference model: {pc, inst}, head at index 0

   if_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .enq_valid_i(enq_valid_i), .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i),
      .enq_ready_o(enq_ready_o), .deq_valid_o(deq_valid_o),
      .deq_pc_o(deq_pc_o), .deq_inst_o(deq_inst_o),
      .deq_ready_i(deq_ready_i), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected {enq_ready, deq_valid, deq_pc, deq_inst, count} from the model.
   function automatic logic [68:0] model_out();
      logic        er, dv;
      logic [31:0] pc, inst;
      er   = (mq.size() < DEPTH) && !flush_i;
      dv   = (mq.size() != 0) && !flush_i;
      pc   = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
      inst = (mq.size() != 0) ? mq[0][31:0]  : NOP;
      return {er, dv, pc, inst, 3'(mq.size())};
   endfunction

   function automatic logic [68:0] dut_out();
      return {enq_ready_o, deq_valid_o, deq_pc_o, deq_inst_o, count_o};
   endfunction

   task automatic drive(input logic r, input logic f, input logic ev,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic dr);
      @(negedge clk_i);
      rst_i = r; flush_i = f; enq_valid_i = ev;
      enq_pc_i = pc; enq_inst_i = inst; deq_ready_i = dr;
      #1;
   endtask

   // Advance one rising edge and update the model from the applied inputs.
   task automatic tick();
      bit do_enq, do_deq;
      do_enq = enq_valid_i && (mq.size() < DEPTH) && !flush_i;
      do_deq = deq_ready_i && (mq.size() != 0) && !flush_i;
      @(posedge clk_i);
      if (rst_i || flush_i) mq.delete();
      else begin
         if (do_deq) void'(mq.pop_front());
         if (do_enq) mq.push_back({enq_pc_i, enq_inst_i});
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if ({enq_ready_o, deq_valid_o, deq_pc_o, deq_inst_o, count_o} !==
          {1'b1, 1'b0, 32'h0, NOP, 3'd0}) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", dut_out(),
                  {1'b1, 1'b0, 32'h0, NOP, 3'd0});
      end
   endtask

   task automatic test_basic();
      drive(0, 0, 1, 32'h100, 32'h0050_0093, 1);
      checks++;
      if (deq_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL basic_no_bypass: deq_valid=%b enq_ready=%b want 0/1", deq_valid_o, enq_ready_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if ({deq_valid_o, deq_pc_o, deq_inst_o} !== {1'b1, 32'h100, 32'h0050_0093}) begin
         errors++;
         $display("FAIL basic_head: got v=%b pc=%h inst=%h want 1/100/00500093", deq_valid_o, deq_pc_o, deq_inst_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (count_o !== 3'd0 || deq_inst_o !== NOP || deq_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_empty: count=%0d inst=%h v=%b want 0/%h/0", count_o, deq_inst_o, deq_valid_o, NOP);
      end
      tick();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 32'(i * 4), $urandom, 0);
         tick();
      end
      drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
      checks++;
      if (count_o !== 3'd4 || enq_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL fill_full: count=%0d enq_ready=%b want 4/0", count_o, enq_ready_o);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         checks++;
         if (deq_pc_o !== 32'(i * 4) || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL fill_drain[%0d]: pc=%h want %h (out %h model %h)", i, deq_pc_o, 32'(i * 4), dut_out(), model_out());
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (count_o !== 3'd0) begin
         errors++;
         $display("FAIL fill_after_drain: count=%0d want 0", count_o);
      end
      tick();
   endtask

   task automatic test_simul();
      logic [31:0] exp_pc [4] = '{32'h308, 32'h30C, 32'h310, 32'h314};
      drive(0, 0, 1, 32'h300, 32'hA0, 0); tick();
      drive(0, 0, 1, 32'h304, 32'hA1, 0); tick();
      drive(0, 0, 1, 32'h308, 32'hA2, 1);
      checks++;
      if (enq_ready_o !== 1'b1 || deq_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL simul_handshake: enq_ready=%b deq_valid=%b want 1/1", enq_ready_o, deq_valid_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (count_o !== 3'd2 || deq_pc_o !== 32'h304) begin
         errors++;
         $display("FAIL simul_count: count=%0d pc=%h want 2/304", count_o, deq_pc_o);
      end
      drive(0, 0, 1, 32'h30C, 32'hA3, 0); tick();
      drive(0, 0, 1, 32'h310, 32'hA4, 0); tick();
      drive(0, 0, 1, 32'h314, 32'hA5, 1);
      checks++;
      if (enq_ready_o !== 1'b0 || deq_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL simul_full_block: enq_ready=%b deq_valid=%b want 0/1", enq_ready_o, deq_valid_o);
      end
      tick();
      drive(0, 0, 1, 32'h314, 32'hA5, 0);
      checks++;
      if (enq_ready_o !== 1'b1 || count_o !== 3'd3) begin
         errors++;
         $display("FAIL simul_slot_freed: enq_ready=%b count=%0d want 1/3", enq_ready_o, count_o);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         checks++;
         if (deq_pc_o !== exp_pc[i] || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL simul_drain[%0d]: pc=%h want %h (out %h model %h)", i, deq_pc_o, exp_pc[i], dut_out(), model_out());
         end
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 32'h400 + 32'(i * 4), $urandom, 0);
         tick();
      end
      drive(0, 1, 1, 32'h500, 32'h55, 1);
      checks++;
      if (deq_valid_o !== 1'b0 || enq_ready_o !== 1'b0 || count_o !== 3'd3) begin
         errors++;
         $display("FAIL flush_cycle: deq_valid=%b enq_ready=%b count=%0d want 0/0/3", deq_valid_o, enq_ready_o, count_o);
      end
      tick();
      drive(0, 0, 1, 32'h200, 32'h0020_0113, 0);
      checks++;
      if (count_o !== 3'd0) begin
         errors++;
         $display("FAIL flush_count: count=%0d want 0", count_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 1);
      checks++;
      if (deq_valid_o !== 1'b1 || deq_pc_o !== 32'h200 || deq_inst_o !== 32'h0020_0113) begin
         errors++;
         $display("FAIL flush_first_after: v=%b pc=%h inst=%h want 1/200/00200113", deq_valid_o, deq_pc_o, deq_inst_o);
      end
      tick();
   endtask

   task automatic test_wrap_reset();
      logic [63:0] sent[$];
      logic [63:0] got[$];
      int          n = 0;
      int          cyc = 0;
      while (got.size() < 10 && cyc < 200) begin
         logic        ev, dr;
         logic [31:0] pc, inst;
         ev   = (n < 10);
         pc   = 32'h1000 + 32'(n * 4);
         inst = $urandom;
         dr   = 1'($urandom_range(0, 1));
         drive(0, 0, ev, pc, inst, dr);
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL wrap_cycle%0d: out %h model %h", cyc, dut_out(), model_out());
         end
         if (deq_valid_o && dr) got.push_back({deq_pc_o, deq_inst_o});
         if (ev && mq.size() < DEPTH) begin
            sent.push_back({pc, inst});
            n++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (got.size() != 10 || got != sent) begin
         errors++;
         $display("FAIL wrap_order: got %0d entries, want 10 in issue order", got.size());
      end
      drive(0, 0, 1, 32'h600, 32'h1, 0); tick();
      drive(0, 0, 1, 32'h604, 32'h2, 0); tick();
      drive(1, 0, 1, 32'h608, 32'h3, 1);
      checks++;
      if (count_o !== 3'd2) begin
         errors++;
         $display("FAIL rst_mid_pre: count=%0d want 2", count_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || deq_inst_o !== NOP) begin
         errors++;
         $display("FAIL rst_mid_post: count=%0d v=%b inst=%h want 0/0/%h", count_o, deq_valid_o, deq_inst_o, NOP);
      end
      tick();
   endtask

   task automatic test_random_soak();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0));
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL soak_cycle%0d: out %h model %h", c, dut_out(), model_out());
         end
         tick();
      end
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0;
      enq_pc_i = '0; enq_inst_i = '0; deq_ready_i = 1'b0;
      test_reset();
      test_basic();
      test_fill();
      test_simul();
      test_flush();
      test_wrap_reset();
      test_random_soak();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of instruction entries; power of two, minimum 2.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013: instruction presented to decode when the queue is empty.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: redirect/flush request; discards all queued instructions.
REQ-006 SHALL have port enq_valid_i, input, 1 bit: fetch presents a valid instruction.
REQ-007 SHALL have port enq_pc_i, input, 32 bits: PC of the presented instruction.
REQ-008 SHALL have port enq_inst_i, input, 32 bits: instruction word returned by the I-cache.
REQ-009 SHALL have port enq_ready_o, output, 1 bit: queue can accept an instruction this cycle.
REQ-010 SHALL have port deq_valid_o, output, 1 bit: an instruction is presented to decode.
REQ-011 SHALL have port deq_pc_o, output, 32 bits: PC of the head entry.
REQ-012 SHALL have port deq_inst_o, output, 32 bits: instruction of the head entry.
REQ-013 SHALL have port deq_ready_i, input, 1 bit: decode accepts the head entry this cycle.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-015 SHALL be a circular FIFO with read pointer, write pointer and occupancy counter; pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-016 SHALL perform an enqueue when enq_valid_i && enq_ready_o: writes {enq_pc_i, enq_inst_i} at the write pointer and increments it.
REQ-017 SHALL perform a dequeue when deq_valid_o && deq_ready_i: increments the read pointer.
REQ-018 SHALL drive enq_ready_o = (count_o < DEPTH) && !flush_i; enq_ready_o SHALL NOT depend on deq_ready_i.
REQ-019 SHALL drive deq_valid_o = (count_o != 0) && !flush_i.
REQ-020 SHALL drive deq_pc_o and deq_inst_o from the entry at the read pointer when count_o != 0; otherwise 32'h0 and NOP_INST.
REQ-021 SHALL give a minimum latency of 1 cycle: an instruction enqueued at edge N appears on deq_* in the cycle after edge N. There SHALL be no combinational enq-to-deq bypass.
REQ-022 SHALL leave count_o unchanged on a simultaneous enqueue and dequeue, increment it on enqueue only, and decrement it on dequeue only.
REQ-023 SHALL, when full (count_o == DEPTH), hold enq_ready_o = 0 even if a dequeue occurs in the same cycle; the freed slot becomes available the following cycle.
REQ-024 SHALL, when empty, perform no dequeue regardless of deq_ready_i; pointers and count are unchanged.
REQ-025 SHALL give flush_i priority over enqueue and dequeue: at the next edge both pointers and count_o become 0. The enqueue and dequeue in the flush cycle are both suppressed.
REQ-026 SHALL hold entry contents stable under backpressure: while deq_valid_o && !deq_ready_i, deq_pc_o and deq_inst_o do not change.
REQ-027 SHALL never overflow or underflow count_o; any attempt is blocked by REQ-018 and REQ-024.
REQ-028 SHALL reject a DEPTH that is not a power of two or is less than 2 at elaboration.

Reset
REQ-029 SHALL, when rst_i is high at an edge, set read pointer, write pointer and count_o to 0; rst_i takes priority over flush_i and all handshakes.
REQ-030 SHALL, after reset, drive deq_valid_o=0, deq_pc_o=0, deq_inst_o=NOP_INST, enq_ready_o=1 (when flush_i=0), count_o=0; storage array need not be reset.
REQ-031 SHALL, when reset is asserted mid-operation, discard all entries at that edge, identically to REQ-029.

Verification
REQ-032 SHALL cover basic flow: reset, then enqueue {pc=0x100, inst=0x00500093} with deq_ready_i=1 -> next cycle deq_valid_o=1, deq_pc_o=0x100, deq_inst_o=0x00500093; following cycle count_o=0 and deq_inst_o=0x00000013.
REQ-033 SHALL cover fill to full: deq_ready_i=0, enqueue pcs 0x0,0x4,0x8,0xC -> count_o=4, enq_ready_o=0; a fifth enq_valid_i is not accepted; draining yields 0x0,0x4,0x8,0xC in order.
REQ-034 SHALL cover simultaneous enqueue and dequeue: at count_o=2, enqueue and dequeue in the same cycle -> count_o stays 2, order preserved; at full with deq_ready_i=1, enqueue blocked that cycle and accepted the next.
REQ-035 SHALL cover flush: at count_o=3, assert flush_i with enq_valid_i=1 -> deq_valid_o=0 and enq_ready_o=0 that cycle; next cycle count_o=0; the new enqueue after flush of pc=0x200 is output as the first entry.
REQ-036 SHALL cover wrap-around and reset mid-operation: stream 10 instructions with random deq_ready_i -> all emerge in order with correct pc/inst; then rst_i at count_o=2 -> next cycle count_o=0, deq_valid_o=0.
